updown_sched: RTL and testbench
===============================

# updown_sched

Sequencer and arbiter that drives the `count`/`inc` controls of the 3-bit up/down counter (`bit3`) on behalf of two requesters.
- The up-requester and down-requester each ask for a burst of 1..2^LEN_W counter steps in their own direction.
- The block grants one burst at a time, holds the counter enable for exactly that many cycles and counts carry/borrow (`cout`) events during the burst.
- It sits between the requesting logic and a single `bit3` instance; `bit3` keeps its own `set` tie.

## Interface
Parameters:
- LEN_W, default 3: width of the burst-length fields; burst length is field value + 1 steps.
- WRAP_W, default 2: width of the wrap-event counter.

Ports:
- clk  in  1  system clock, rising edge.
- set  in  1  reset, asynchronous, active-high.
- req_up  in  1  up-burst request; held until `gnt_up`.
- len_up  in  LEN_W  up-burst length minus one.
- req_dn  in  1  down-burst request; held until `gnt_dn`.
- len_dn  in  LEN_W  down-burst length minus one.
- abort  in  1  terminate the current burst.
- cout  in  1  carry/borrow from `bit3`.
- gnt_up  out  1  one-cycle accept pulse for the up request.
- gnt_dn  out  1  one-cycle accept pulse for the down request.
- count  out  1  counter enable to `bit3`.
- inc  out  1  counter direction to `bit3`: 1 = up, 0 = down.
- busy  out  1  high while a burst is in progress (RUN or DONE).
- done  out  1  one-cycle pulse marking the end of a burst.
- wrap_cnt  out  WRAP_W  `cout` events seen in the last burst; saturates at all-ones.

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- On `set` (asynchronous):
  - state returns to IDLE.
  - `gnt_up`, `gnt_dn`, `count`, `inc`, `busy`, `done`, `wrap_cnt` and the remaining-steps register go to 0.
  - The last-granted flag is set to DN, so UP wins the first tie.
- IDLE:
  - If any request is high at the edge: grant the arbitration winner, load `rem` with its `len`, set `inc` to its direction, clear `wrap_cnt`, and move to RUN.
  - On the same edge: pulse the matching `gnt_*`, set `count`=1, set `busy`=1.
- Arbitration:
  - A single requester always wins.
  - With both requesting, the winner depends on the macro (see Configuration).
  - A request dropped before its grant is a withdrawal; no grant is issued.
- RUN:
  - `count`=1 and `inc` is constant for the whole burst.
  - At each edge: if `rem`==0 or `abort`=1, go to DONE with `count`=0, `done`=1; otherwise decrement `rem`.
  - At each edge where `cout`=1, increment `wrap_cnt`, saturating.
- DONE: lasts one cycle. Then go to IDLE with `done`=0 and `busy`=0. `wrap_cnt` holds its value until the next grant.
- Requests are ignored in RUN and DONE; they stay pending.
- `abort` is ignored outside RUN.

## Timing
- Grant latency: a request sampled high at IDLE edge E0 gives `gnt_*` and `count` high after E0.
- Burst length: `count` stays high for exactly len+1 cycles.
- DONE follows the last step: `done` is high for one cycle and `count` is low.
- Back-to-back bursts: minimum gap of 2 `count`-low cycles (the DONE cycle and the IDLE cycle).
- Abort: `abort` sampled at RUN edge Ek means `count` is low after Ek. Steps completed = k.
- Abort on the natural last step gives the same result as normal completion.
- Reset mid-burst: `count` drops asynchronously; no `done` pulse is produced.
- `cout` is sampled only while `count`=1, and is counted at the same edge as the step it belongs to.

## Configuration
- UPDOWN_SCHED_FAIR_EN defined: round-robin arbitration. On a tie, grant the direction not granted last. The last-granted flag updates on every grant.
- UPDOWN_SCHED_FAIR_EN undefined: fixed priority, UP over DN. The last-granted flag is not implemented.

## Structure
- Package `updown_sched_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - constants DIR_UP=1'b1 and DIR_DN=1'b0;
  - default LEN_W and WRAP_W.
- Sub-module `rr_arb2`: 2-way arbiter with a request pair in and a one-hot grant out. It contains the last-granted flag and reduces to fixed priority when the macro is undefined.

## Test plan
- Reset, then `req_up`=1 with `len_up`=3 → one cycle later `gnt_up`=1; `count`=1 and `inc`=1 for 4 cycles; then `done`=1 for one cycle.
- Both requesting, `len_up`=0 and `len_dn`=1, with FAIR_EN defined → UP burst (1 step), then DN burst (2 steps, `inc`=0), with a 2-cycle gap between them. Without FAIR_EN and `req_up` held → UP is granted twice before DN.
- `len_dn`=7 driving `bit3` from q=2 → 8 steps down, `cout` seen at one step (borrow at 0), `wrap_cnt`=1.
- Up burst of 8 steps from q=0 with `cout` forced high every cycle → `wrap_cnt` saturates at 3.
- `abort` raised at the 2nd RUN edge of a `len`=5 burst → 2 steps completed, `count` low, `done` pulse, then IDLE.
- `set` asserted mid-burst → `count`, `busy` and `gnt_*` low immediately, no `done` pulse; after release UP wins a tie.

Source files
------------

// File: rtl/updown_sched_pkg.sv
// Shared types and constants for the up/down burst sequencer.
// Arbitration mode is selected by UPDOWN_SCHED_FAIR_EN.
package updown_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int LEN_W_DEF  = 3;
  localparam int WRAP_W_DEF = 2;

endpackage

// File: rtl/updown_sched_arb.sv
// rr_arb2: two-way arbiter, req/gnt bit 1 = up, bit 0 = down.
// UPDOWN_SCHED_FAIR_EN selects round-robin, else fixed up-first.
module rr_arb2
  import updown_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

`ifdef UPDOWN_SCHED_FAIR_EN
  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= DIR_DN;
    end else if (take && (|req)) begin
      last <= gnt[1] ? DIR_UP : DIR_DN;
    end
  end

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b11:   gnt = (last == DIR_DN) ? 2'b10 : 2'b01;
      2'b10:   gnt = 2'b10;
      2'b01:   gnt = 2'b01;
      default: gnt = 2'b00;
    endcase
  end
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst, take};

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b11:   gnt = 2'b10;
      2'b10:   gnt = 2'b10;
      2'b01:   gnt = 2'b01;
      default: gnt = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/updown_sched.sv
// Burst sequencer driving count/inc of a bit3 up/down counter.
// Define UPDOWN_SCHED_FAIR_EN for round-robin tie breaking.
module updown_sched
  import updown_sched_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              set,
  input  logic              req_up,
  input  logic [LEN_W-1:0]  len_up,
  input  logic              req_dn,
  input  logic [LEN_W-1:0]  len_dn,
  input  logic              abort,
  input  logic              cout,
  output logic              gnt_up,
  output logic              gnt_dn,
  output logic              count,
  output logic              inc,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [LEN_W-1:0]  REM_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  state_e           state;
  logic [LEN_W-1:0] rem;
  logic [1:0]       pick;
  logic             idle;

  assign idle = (state == IDLE);

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (set),
    .req  ({req_up, req_dn}),
    .take (idle),
    .gnt  (pick)
  );

  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      state    <= IDLE;
      rem      <= '0;
      gnt_up   <= 1'b0;
      gnt_dn   <= 1'b0;
      count    <= 1'b0;
      inc      <= DIR_DN;
      busy     <= 1'b0;
      done     <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      gnt_up <= 1'b0;
      gnt_dn <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|pick) begin
            state    <= RUN;
            rem      <= pick[1] ? len_up : len_dn;
            inc      <= pick[1] ? DIR_UP : DIR_DN;
            wrap_cnt <= '0;
            gnt_up   <= pick[1];
            gnt_dn   <= pick[0];
            count    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // cout belongs to the step that ends at this edge
          if (count && cout && (wrap_cnt != WRAP_MAX)) begin
            wrap_cnt <= wrap_cnt + WRAP_ONE;
          end
          if ((rem == '0) || abort) begin
            state <= DONE;
            count <= 1'b0;
            done  <= 1'b1;
          end else begin
            rem <= rem - REM_ONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          count <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_sched.sv
// Directed bench for updown_sched with a behavioural bit3 counter.
// Expectations follow UPDOWN_SCHED_FAIR_EN when it is defined.
module tb_updown_sched;

  logic       clk;
  logic       set;
  logic       req_up;
  logic [2:0] len_up;
  logic       req_dn;
  logic [2:0] len_dn;
  logic       abort;
  logic       cout;
  logic       gnt_up;
  logic       gnt_dn;
  logic       count;
  logic       inc;
  logic       busy;
  logic       done;
  logic [1:0] wrap_cnt;

  logic [2:0] q;
  logic       q_load;
  logic [2:0] q_val;
  logic       force_cout;

  int n_chk;
  int n_fail;

  updown_sched dut (
    .clk      (clk),
    .set      (set),
    .req_up   (req_up),
    .len_up   (len_up),
    .req_dn   (req_dn),
    .len_dn   (len_dn),
    .abort    (abort),
    .cout     (cout),
    .gnt_up   (gnt_up),
    .gnt_dn   (gnt_dn),
    .count    (count),
    .inc      (inc),
    .busy     (busy),
    .done     (done),
    .wrap_cnt (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit3 stand-in: carry on 7->0 going up, borrow on 0->7 going down
  always @(posedge clk or posedge set) begin
    if (set) q <= 3'd0;
    else if (q_load) q <= q_val;
    else if (count) q <= inc ? q + 3'd1 : q - 3'd1;
  end

  assign cout = force_cout |
    (count & (inc ? (q == 3'd7) : (q == 3'd0)));

  typedef struct {
    int ru; int lu; int rd; int ld; int ab;
    int gu; int gd; int cn; int in; int bz; int dn; int wr;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_str(input string nm, input string act,
                         input string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", nm, act, exp);
    end
  endtask

  // called just after a grant edge; returns after the done pulse
  task automatic run_burst(output int steps, output int ok);
    steps = 0;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (count) steps++;
      if (done) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_tie();
    int    pend_up;
    int    pend_dn;
    int    nrun;
    int    ngap;
    int    run;
    int    gap;
    logic  prev;
    string order;
    int    runs[3];
    int    incs[3];
    int    gaps[2];
    string exp_order;
    int    exp_runs[3];
    int    exp_incs[3];
    pend_up = 2;
    pend_dn = 1;
    nrun = 0;
    ngap = 0;
    run = 0;
    gap = 0;
    prev = 1'b0;
    order = "";
    runs = '{-1, -1, -1};
    incs = '{-1, -1, -1};
    gaps = '{-1, -1};
    len_up = 3'd0;
    len_dn = 3'd1;
    for (int c = 0; c < 30; c++) begin
      req_up = (pend_up > 0);
      req_dn = (pend_dn > 0);
      @(posedge clk);
      #1;
      if (gnt_up) begin
        pend_up--;
        order = {order, "U"};
      end
      if (gnt_dn) begin
        pend_dn--;
        order = {order, "D"};
      end
      if (count) begin
        if (!prev) begin
          if (nrun > 0 && ngap < 2) begin
            gaps[ngap] = gap;
            ngap++;
          end
          if (nrun < 3) incs[nrun] = int'(inc);
          run = 0;
        end
        run++;
        gap = 0;
      end else begin
        if (prev && nrun < 3) begin
          runs[nrun] = run;
          nrun++;
        end
        gap++;
      end
      prev = count;
      @(negedge clk);
    end
    req_up = 1'b0;
    req_dn = 1'b0;
`ifdef UPDOWN_SCHED_FAIR_EN
    exp_order = "UDU";
    exp_runs = '{1, 2, 1};
    exp_incs = '{1, 0, 1};
`else
    exp_order = "UUD";
    exp_runs = '{1, 1, 2};
    exp_incs = '{1, 1, 0};
`endif
    chk_str("tie grant order", order, exp_order);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("tie burst%0d len", k), runs[k], exp_runs[k]);
      chk($sformatf("tie burst%0d inc", k), incs[k], exp_incs[k]);
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("tie gap%0d", k), gaps[k], 2);
    end
  endtask

  initial begin
    int steps;
    int ok;
    n_chk = 0;
    n_fail = 0;
    req_up = 1'b0;
    len_up = 3'd0;
    req_dn = 1'b0;
    len_dn = 3'd0;
    abort = 1'b0;
    q_load = 1'b0;
    q_val = 3'd0;
    force_cout = 1'b0;
    set = 1'b1;

    // {ru,lu,rd,ld,ab, gu,gd,cn,in,bz,dn,wr}
    tbl[0]  = '{1, 3, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{1, 5, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    @(negedge clk);
    chk("rst count", int'(count), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst gnt", int'({gnt_up, gnt_dn}), 0);
    chk("rst done", int'(done), 0);
    chk("rst inc", int'(inc), 0);
    chk("rst wrap", int'(wrap_cnt), 0);
    @(negedge clk);
    set = 1'b0;

    for (int i = 0; i < 14; i++) begin
      req_up = 1'(tbl[i].ru);
      len_up = 3'(tbl[i].lu);
      req_dn = 1'(tbl[i].rd);
      len_dn = 3'(tbl[i].ld);
      abort  = 1'(tbl[i].ab);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d gnt_up", i), int'(gnt_up), tbl[i].gu);
      chk($sformatf("row%0d gnt_dn", i), int'(gnt_dn), tbl[i].gd);
      chk($sformatf("row%0d count", i), int'(count), tbl[i].cn);
      chk($sformatf("row%0d inc", i), int'(inc), tbl[i].in);
      chk($sformatf("row%0d busy", i), int'(busy), tbl[i].bz);
      chk($sformatf("row%0d done", i), int'(done), tbl[i].dn);
      chk($sformatf("row%0d wrap", i), int'(wrap_cnt), tbl[i].wr);
      @(negedge clk);
    end
    abort = 1'b0;
    chk("table steps q", int'(q), 5);

    run_tie();

    // 8 down steps from q=2, one borrow when leaving 0
    q_val = 3'd2;
    q_load = 1'b1;
    @(negedge clk);
    q_load = 1'b0;
    req_dn = 1'b1;
    len_dn = 3'd7;
    @(posedge clk);
    #1;
    req_dn = 1'b0;
    chk("dn7 gnt_dn", int'(gnt_dn), 1);
    run_burst(steps, ok);
    chk("dn7 done seen", ok, 1);
    chk("dn7 steps", steps, 8);
    chk("dn7 wrap", int'(wrap_cnt), 1);
    chk("dn7 end q", int'(q), 2);
    @(negedge clk);

    // forced cout on every step saturates the event count
    q_val = 3'd0;
    q_load = 1'b1;
    @(negedge clk);
    q_load = 1'b0;
    force_cout = 1'b1;
    req_up = 1'b1;
    len_up = 3'd7;
    @(posedge clk);
    #1;
    req_up = 1'b0;
    run_burst(steps, ok);
    chk("sat done seen", ok, 1);
    chk("sat steps", steps, 8);
    chk("sat wrap", int'(wrap_cnt), 3);
    @(negedge clk);
    force_cout = 1'b0;
    @(posedge clk);
    #1;
    chk("sat hold busy", int'(busy), 0);
    chk("sat hold wrap", int'(wrap_cnt), 3);
    @(negedge clk);
    req_up = 1'b1;
    len_up = 3'd0;
    @(posedge clk);
    #1;
    req_up = 1'b0;
    chk("regrant wrap clr", int'(wrap_cnt), 0);
    run_burst(steps, ok);
    chk("regrant steps", steps, 1);
    @(negedge clk);
    @(negedge clk);

    // asynchronous reset in the middle of a burst
    req_up = 1'b1;
    len_up = 3'd5;
    @(posedge clk);
    #1;
    req_up = 1'b0;
    chk("mid gnt_up", int'(gnt_up), 1);
    @(posedge clk);
    #1;
    chk("mid count", int'(count), 1);
    #2;
    set = 1'b1;
    #1;
    chk("async count", int'(count), 0);
    chk("async busy", int'(busy), 0);
    chk("async gnt", int'({gnt_up, gnt_dn}), 0);
    chk("async done", int'(done), 0);
    @(posedge clk);
    #1;
    chk("in rst done", int'(done), 0);
    @(negedge clk);
    set = 1'b0;
    req_up = 1'b1;
    req_dn = 1'b1;
    len_up = 3'd0;
    len_dn = 3'd0;
    @(posedge clk);
    #1;
    req_up = 1'b0;
    chk("post rst gnt_up", int'(gnt_up), 1);
    chk("post rst gnt_dn", int'(gnt_dn), 0);
    run_burst(steps, ok);
    chk("post rst done", ok, 1);
    @(negedge clk);
    req_dn = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
